// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared types and constants for the RTC bus sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rtc_bus_pkg;

    // 3-bit state encoding, sequential along the access
    localparam logic [2:0] ENC_IDLE     = 3'd0;
    localparam logic [2:0] ENC_A_SETUP  = 3'd1;
    localparam logic [2:0] ENC_A_STROBE = 3'd2;
    localparam logic [2:0] ENC_A_HOLD   = 3'd3;
    localparam logic [2:0] ENC_D_SETUP  = 3'd4;
    localparam logic [2:0] ENC_D_STROBE = 3'd5;
    localparam logic [2:0] ENC_D_HOLD   = 3'd6;
    localparam logic [2:0] ENC_DONE     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = ENC_IDLE,
        ST_A_SETUP  = ENC_A_SETUP,
        ST_A_STROBE = ENC_A_STROBE,
        ST_A_HOLD   = ENC_A_HOLD,
        ST_D_SETUP  = ENC_D_SETUP,
        ST_D_STROBE = ENC_D_STROBE,
        ST_D_HOLD   = ENC_D_HOLD,
        ST_DONE     = ENC_DONE
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Registered bus/status outputs, decoded together
    typedef struct packed {
        logic busy;
        logic done;
        logic bus_oe;
        logic mux_sel;
        logic cs_n;
        logic ad_n;
        logic wr_n;
        logic rd_n;
    } bus_out_t;

    localparam bus_out_t BUS_IDLE = '{busy: 1'b0, done: 1'b0, bus_oe: 1'b0, mux_sel: 1'b0,
                                      cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1};

    // True for the six timed address/data phases
    function automatic logic is_phase(input state_t s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Request and pad-side signal bundle of the RTC bus sequencer.
// Latency: none (wires only).
// Backpressure: requests are only taken while the sequencer is idle (busy low).
interface rtc_bus_sequencer_if;
    logic       start_wr;
    logic       start_rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] ad_in;
    logic [7:0] mux_ch0;
    logic [7:0] mux_ch1;
    logic       mux_sel;
    logic       bus_oe;
    logic       cs_n;
    logic       ad_n;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] rdata;
    logic       busy;
    logic       done;

    // Sequencer side
    modport slave (
        input  start_wr, start_rd, addr, wdata, ad_in,
        output mux_ch0, mux_ch1, mux_sel, bus_oe, cs_n, ad_n, wr_n, rd_n, rdata, busy, done
    );

    // Requestor / pad side
    modport master (
        output start_wr, start_rd, addr, wdata, ad_in,
        input  mux_ch0, mux_ch1, mux_sel, bus_oe, cs_n, ad_n, wr_n, rd_n, rdata, busy, done
    );
endinterface

// File: rtl/rtc_bus_sequencer_phase_timer.sv
// Loadable down-counter timing one bus phase of PHASE_CYC cycles.
// Latency: phase_end high in the PHASE_CYC-th cycle after load.
// Backpressure: none; load always restarts the count.
module rtc_phase_timer #(
    parameter int PHASE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic phase_end
);
    localparam int CW = $clog2(PHASE_CYC + 1);
    localparam logic [CW-1:0] RELOAD = CW'(PHASE_CYC);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Reload on phase entry, otherwise count down and park at 1
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = RELOAD;
        end else if (count_q > ONE) begin
            count_d = count_q - ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign phase_end = (count_q == ONE) || (PHASE_CYC == 1);
endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences one multiplexed address/data access on the 8-bit RTC bus per request.
// Latency: done pulses 6*PHASE_CYC+1 cycles after the accepting edge; idle the cycle after.
// Backpressure: start_wr/start_rd are ignored while busy; no queuing.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int PHASE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_bus_sequencer_if.slave   bus
);
    state_t     state_q, state_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    bus_out_t   out_q, out_d;

    logic accept;
    logic load;
    logic phase_end;

    assign accept = (state_q == ST_IDLE) && (bus.start_wr || bus.start_rd);
    assign load   = accept || (is_phase(state_q) && phase_end);

    rtc_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .phase_end (phase_end)
    );

    // Next state, request latches and read capture
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (accept) begin
            rw_d    = bus.start_wr ? RW_WRITE : RW_READ;
            addr_d  = bus.addr;
            wdata_d = bus.wdata;
        end
        if ((state_q == ST_D_STROBE) && phase_end && (rw_q == RW_READ)) begin
            rdata_d = bus.ad_in;
        end
        case (state_q)
            ST_IDLE:     if (accept)    state_d = ST_A_SETUP;
            ST_A_SETUP:  if (phase_end) state_d = ST_A_STROBE;
            ST_A_STROBE: if (phase_end) state_d = ST_A_HOLD;
            ST_A_HOLD:   if (phase_end) state_d = ST_D_SETUP;
            ST_D_SETUP:  if (phase_end) state_d = ST_D_STROBE;
            ST_D_STROBE: if (phase_end) state_d = ST_D_HOLD;
            ST_D_HOLD:   if (phase_end) state_d = ST_DONE;
            ST_DONE:                    state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so registered outputs line up with state_q
    always_comb begin
        out_d = BUS_IDLE;
        case (state_d)
            ST_A_SETUP, ST_A_HOLD: begin
                out_d.busy   = 1'b1;
                out_d.ad_n   = 1'b0;
                out_d.bus_oe = 1'b1;
            end
            ST_A_STROBE: begin
                out_d.busy   = 1'b1;
                out_d.ad_n   = 1'b0;
                out_d.bus_oe = 1'b1;
                out_d.cs_n   = 1'b0;
                out_d.wr_n   = 1'b0;
            end
            ST_D_SETUP, ST_D_HOLD: begin
                out_d.busy    = 1'b1;
                out_d.mux_sel = 1'b1;
                out_d.bus_oe  = (rw_d == RW_WRITE);
            end
            ST_D_STROBE: begin
                out_d.busy    = 1'b1;
                out_d.mux_sel = 1'b1;
                out_d.bus_oe  = (rw_d == RW_WRITE);
                out_d.cs_n    = 1'b0;
                out_d.wr_n    = (rw_d != RW_WRITE);
                out_d.rd_n    = (rw_d != RW_READ);
            end
            ST_DONE: begin
                out_d.busy    = 1'b1;
                out_d.done    = 1'b1;
                out_d.mux_sel = out_q.mux_sel;
            end
            default: ;
        endcase
    end

    // State, latches and output registers; reset aborts any access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            out_q   <= BUS_IDLE;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            out_q   <= out_d;
        end
    end

    assign bus.mux_ch0 = addr_q;
    assign bus.mux_ch1 = wdata_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = out_q.busy;
    assign bus.done    = out_q.done;
    assign bus.bus_oe  = out_q.bus_oe;
    assign bus.mux_sel = out_q.mux_sel;
    assign bus.cs_n    = out_q.cs_n;
    assign bus.ad_n    = out_q.ad_n;
    assign bus.wr_n    = out_q.wr_n;
    assign bus.rd_n    = out_q.rd_n;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: PHASE_CYC=4 and PHASE_CYC=1 instances.
// Latency: cycle-by-cycle comparison against hand-derived per-cycle expectations.
// Backpressure: exercises ignored requests while busy and back-to-back requests.
module tb_rtc_bus_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_wr = 1'b0;
    logic       start_rd = 1'b0;
    logic       sel1 = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] ad_in = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [7:0] VEC_IDLE = 8'h0F;

    always #5 clk = ~clk;

    rtc_bus_sequencer_if bus4 ();
    rtc_bus_sequencer_if bus1 ();

    assign bus4.start_wr = start_wr & ~sel1;
    assign bus4.start_rd = start_rd & ~sel1;
    assign bus4.addr     = addr;
    assign bus4.wdata    = wdata;
    assign bus4.ad_in    = ad_in;
    assign bus1.start_wr = start_wr & sel1;
    assign bus1.start_rd = start_rd & sel1;
    assign bus1.addr     = addr;
    assign bus1.wdata    = wdata;
    assign bus1.ad_in    = ad_in;

    rtc_bus_sequencer #(.PHASE_CYC(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    rtc_bus_sequencer #(.PHASE_CYC(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // {busy, done, bus_oe, mux_sel, cs_n, ad_n, wr_n, rd_n}
    logic [7:0] obs4, obs1;
    assign obs4 = {bus4.busy, bus4.done, bus4.bus_oe, bus4.mux_sel,
                   bus4.cs_n, bus4.ad_n, bus4.wr_n, bus4.rd_n};
    assign obs1 = {bus1.busy, bus1.done, bus1.bus_oe, bus1.mux_sel,
                   bus1.cs_n, bus1.ad_n, bus1.wr_n, bus1.rd_n};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected control vector for cycle m of an access (m=1 is the first A_SETUP cycle)
    function automatic logic [7:0] exp_vec(input int m, input int p, input bit wr);
        int  ph;
        bit  a, strobe;
        if (m >= 1 && m <= 6 * p) begin
            ph     = (m - 1) / p;
            a      = (ph < 3);
            strobe = (ph == 1) || (ph == 4);
            return {1'b1, 1'b0, a | wr, ~a, ~strobe, ~a,
                    ~((ph == 1) || (ph == 4 && wr)), ~(ph == 4 && !wr)};
        end
        if (m == 6 * p + 1) return 8'hDF;
        return VEC_IDLE;
    endfunction

    // Issue one request at the next edge and follow it for 'last' cycles
    task automatic run_access(input string tag, input int p, input bit req_wr, input bit req_rd,
                              input logic [7:0] a, input logic [7:0] d, input logic [7:0] rd_val,
                              input logic [7:0] rdata_prev, input int last, input int inject,
                              input int abort_at, input bit hold);
        int         m;
        logic [7:0] vec, ch0, ch1, rd;
        sel1 = (p == 1);
        start_wr = req_wr;
        start_rd = req_rd;
        addr = a;
        wdata = d;
        ad_in = 8'h00;
        @(posedge clk); #1;
        if (!hold) begin
            start_wr = 1'b0;
            start_rd = 1'b0;
        end
        for (int n = 1; n <= last; n++) begin
            m = (hold && n > 6 * p + 2) ? n - (6 * p + 2) : n;
            ad_in = (!req_wr && m >= 4 * p + 1 && m <= 5 * p) ? rd_val : 8'h00;
            if (n == inject) begin
                start_rd = 1'b1;
                addr = 8'h33;
            end else if (n == inject + 1) begin
                start_rd = 1'b0;
                addr = a;
            end
            vec = (p == 1) ? obs1 : obs4;
            ch0 = (p == 1) ? bus1.mux_ch0 : bus4.mux_ch0;
            ch1 = (p == 1) ? bus1.mux_ch1 : bus4.mux_ch1;
            rd  = (p == 1) ? bus1.rdata : bus4.rdata;
            check($sformatf("%s c%0d ctl", tag, n), {24'h0, vec}, {24'h0, exp_vec(m, p, req_wr)});
            check($sformatf("%s c%0d ch0", tag, n), {24'h0, ch0}, {24'h0, a});
            check($sformatf("%s c%0d ch1", tag, n), {24'h0, ch1}, {24'h0, d});
            check($sformatf("%s c%0d rdata", tag, n), {24'h0, rd},
                  {24'h0, (!req_wr && n > 5 * p) ? rd_val : rdata_prev});
            if (n == abort_at) begin
                reset = 1'b1;
                #1;
                check($sformatf("%s abort ctl", tag), {24'h0, obs4}, {24'h0, VEC_IDLE});
                check($sformatf("%s abort rdata", tag), {24'h0, bus4.rdata}, 32'h0);
                check($sformatf("%s abort ch0", tag), {24'h0, bus4.mux_ch0}, 32'h0);
                check($sformatf("%s abort ch1", tag), {24'h0, bus4.mux_ch1}, 32'h0);
                ad_in = 8'h00;
                @(posedge clk); #1;
                check($sformatf("%s abort held", tag), {24'h0, obs4}, {24'h0, VEC_IDLE});
                reset = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // 1: reset, then reset asserted again in idle with random inputs
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_wr = 1'($urandom);
            start_rd = 1'($urandom);
            sel1     = 1'($urandom);
            addr     = 8'($urandom);
            wdata    = 8'($urandom);
            ad_in    = 8'($urandom);
            @(posedge clk); #1;
            check($sformatf("rst%0d ctl4", i), {24'h0, obs4}, {24'h0, VEC_IDLE});
            check($sformatf("rst%0d ctl1", i), {24'h0, obs1}, {24'h0, VEC_IDLE});
            check($sformatf("rst%0d rdata", i), {24'h0, bus4.rdata}, 32'h0);
            check($sformatf("rst%0d ch0", i), {24'h0, bus4.mux_ch0}, 32'h0);
            check($sformatf("rst%0d ch1", i), {24'h0, bus4.mux_ch1}, 32'h0);
        end
        start_wr = 1'b0;
        start_rd = 1'b0;
        ad_in = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;

        // 2: write 0x21/0x59
        run_access("wr", 4, 1'b1, 1'b0, 8'h21, 8'h59, 8'h00, 8'h00, 28, -1, -1, 1'b0);
        // 3: read 0x22, pad drives 0xA5 during D_STROBE
        run_access("rd", 4, 1'b0, 1'b1, 8'h22, 8'h00, 8'hA5, 8'h00, 28, -1, -1, 1'b0);
        // 4: both starts -> write; start_rd at cycle 10 ignored; nothing after DONE
        run_access("prio", 4, 1'b1, 1'b1, 8'h21, 8'h59, 8'h00, 8'hA5, 32, 10, -1, 1'b0);
        // 5: reset pulse at cycle 18 of a read, then a normal write
        run_access("abort", 4, 1'b0, 1'b1, 8'h44, 8'h00, 8'h77, 8'hA5, 30, -1, 18, 1'b0);
        run_access("post", 4, 1'b1, 1'b0, 8'h10, 8'h05, 8'h00, 8'h00, 28, -1, -1, 1'b0);
        // 6: PHASE_CYC=1 write, request held -> restart right after IDLE cycle 8
        run_access("p1", 1, 1'b1, 1'b0, 8'h3C, 8'hC3, 8'h00, 8'h00, 10, -1, -1, 1'b1);
        start_wr = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("p1 drain ctl", {24'h0, obs1}, {24'h0, VEC_IDLE});
        check("p4 untouched", {24'h0, obs4}, {24'h0, VEC_IDLE});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
